dla_axi_lite_s: RTL and testbench

// - AXI-Lite subordinate (responder) with a small word-addressed register bank.
// - Other end of the DLA AXI-Lite manager link: terminates manager reads/writes
//   in a fabric-free loopback and serves as a config/status target.
// - Register contents exported flat on regs_o for downstream DLA logic.

---
 rtl/dla_axi_lite_s.sv | 156 +++++++++++++++
 tb/tb_dla_axi_lite_s.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_axi_lite_s.sv
// -----------------------------------------------------------------------------
// dla_axi_lite_s
// AXI-Lite subordinate with a small word-addressed register bank. It terminates
// the DLA AXI-Lite manager link for loopback use and serves as a config/status
// target. The register contents are exported flat on regs_o.
//
// Ports
//   clk_i, rstn_i          clock, synchronous active-low reset
//   aw*/w*/b*              write address, write data, write response channels
//   ar*/r*                 read address, read data channels
//   regs_o                 register k at [k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
//
// Build option
//   DLA_AXI_LITE_S_ADDR_ERR_EN  when defined, out-of-range accesses get SLVERR
//                               (writes dropped, reads return 0). When undefined,
//                               the low address bits select a register (aliasing)
//                               and every response is OKAY.
// -----------------------------------------------------------------------------
module dla_axi_lite_s #(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS       = 8,
   parameter int BASE_ADDR      = 'h5000
) (
   input  logic                               clk_i,
   input  logic                               rstn_i,
   input  logic [AXI_ADDR_WIDTH-1:0]          awaddr_i,
   input  logic                               awvalid_i,
   output logic                               awready_o,
   input  logic [AXI_DATA_WIDTH-1:0]          wdata_i,
   input  logic [AXI_DATA_WIDTH/8-1:0]        wstrb_i,
   input  logic                               wvalid_i,
   output logic                               wready_o,
   output logic [1:0]                         bresp_o,
   output logic                               bvalid_o,
   input  logic                               bready_i,
   input  logic [AXI_ADDR_WIDTH-1:0]          araddr_i,
   input  logic                               arvalid_i,
   output logic                               arready_o,
   output logic [AXI_DATA_WIDTH-1:0]          rdata_o,
   output logic [1:0]                         rresp_o,
   output logic                               rvalid_o,
   input  logic                               rready_i,
   output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] regs_o
);

   localparam int STRB_W    = AXI_DATA_WIDTH / 8;
   localparam int BYTE_BITS = $clog2(STRB_W);
   localparam int IDX_BITS  = $clog2(NUM_REGS);
   localparam int SPAN_BITS = IDX_BITS + BYTE_BITS;
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE = AXI_ADDR_WIDTH'(BASE_ADDR);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

   // one-deep holding buffers for the write address and write data channels
   logic                      aw_full;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic                      w_full;
   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]         w_strb;

   logic [IDX_BITS-1:0] widx;
   logic [IDX_BITS-1:0] ridx;
   logic                wr_ok;
   logic                rd_ok;
   logic                unused_bits;

   // BASE is aligned to the bank span, so the low index bits of the address
   // equal the low bits of (addr - BASE) >> BYTE_BITS without a subtractor.
   assign widx = aw_addr[SPAN_BITS-1:BYTE_BITS];
   assign ridx = araddr_i[SPAN_BITS-1:BYTE_BITS];

`ifdef DLA_AXI_LITE_S_ADDR_ERR_EN
   // alignment also reduces the range check to a compare of the upper bits
   assign wr_ok = (aw_addr[AXI_ADDR_WIDTH-1:SPAN_BITS]  == BASE[AXI_ADDR_WIDTH-1:SPAN_BITS]);
   assign rd_ok = (araddr_i[AXI_ADDR_WIDTH-1:SPAN_BITS] == BASE[AXI_ADDR_WIDTH-1:SPAN_BITS]);
`else
   assign wr_ok = 1'b1;
   assign rd_ok = 1'b1;
`endif

   assign unused_bits = ^{aw_addr[BYTE_BITS-1:0], araddr_i[BYTE_BITS-1:0],
                          aw_addr[AXI_ADDR_WIDTH-1:SPAN_BITS],
                          araddr_i[AXI_ADDR_WIDTH-1:SPAN_BITS], BASE};

   // readies are gated by reset so nothing is accepted while rstn_i is low
   assign awready_o = rstn_i && !aw_full && !bvalid_o;
   assign wready_o  = rstn_i && !w_full  && !bvalid_o;
   assign arready_o = rstn_i && !rvalid_o;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs[k] <= '0;
         end
         aw_full  <= 1'b0;
         aw_addr  <= '0;
         w_full   <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         bvalid_o <= 1'b0;
         bresp_o  <= '0;
         rvalid_o <= 1'b0;
         rdata_o  <= '0;
         rresp_o  <= '0;
      end else begin
         // ---------------- write path ----------------
         if (awvalid_i && awready_o) begin
            aw_full <= 1'b1;
            aw_addr <= awaddr_i;
         end
         if (wvalid_i && wready_o) begin
            w_full <= 1'b1;
            w_data <= wdata_i;
            w_strb <= wstrb_i;
         end
         // both buffers full implies both readies are low, so the clears
         // below never race a new fill
         if (aw_full && w_full) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_o <= 1'b1;
            bresp_o  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (w_strb[b]) begin
                     regs[widx][8*b +: 8] <= w_data[8*b +: 8];
                  end
               end
            end
         end else if (bvalid_o && bready_i) begin
            bvalid_o <= 1'b0;
         end

         // ---------------- read path ----------------
         // regs is sampled before this edge's write lands: read sees old data
         if (arvalid_i && arready_o) begin
            rvalid_o <= 1'b1;
            rdata_o  <= rd_ok ? regs[ridx] : '0;
            rresp_o  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (rvalid_o && rready_i) begin
            rvalid_o <= 1'b0;
         end
      end
   end

   always_comb begin
      regs_o = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         regs_o[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[k];
      end
   end

endmodule

// File: tb/tb_dla_axi_lite_s.sv
// -----------------------------------------------------------------------------
// tb_dla_axi_lite_s
// Self-checking bench for dla_axi_lite_s: directed scenarios plus randomized
// writes/reads compared against an array-based register model. Honours the
// DLA_AXI_LITE_S_ADDR_ERR_EN build option in its expectations.
// -----------------------------------------------------------------------------
module tb_dla_axi_lite_s;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int NR = 8;
   localparam logic [15:0] BASE = 16'h5000;

   logic               clk = 1'b0;
   logic               rstn;
   logic [AW-1:0]      awaddr;
   logic               awvalid;
   logic               awready;
   logic [DW-1:0]      wdata;
   logic [DW/8-1:0]    wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;
   logic [AW-1:0]      araddr;
   logic               arvalid;
   logic               arready;
   logic [DW-1:0]      rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;
   logic [NR*DW-1:0]   regs;

   dla_axi_lite_s #(
      .AXI_ADDR_WIDTH (AW),
      .AXI_DATA_WIDTH (DW),
      .NUM_REGS       (NR),
      .BASE_ADDR      ('h5000)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .awaddr_i  (awaddr),
      .awvalid_i (awvalid),
      .awready_o (awready),
      .wdata_i   (wdata),
      .wstrb_i   (wstrb),
      .wvalid_i  (wvalid),
      .wready_o  (wready),
      .bresp_o   (bresp),
      .bvalid_o  (bvalid),
      .bready_i  (bready),
      .araddr_i  (araddr),
      .arvalid_i (arvalid),
      .arready_o (arready),
      .rdata_o   (rdata),
      .rresp_o   (rresp),
      .rvalid_o  (rvalid),
      .rready_i  (rready),
      .regs_o    (regs)
   );

   always #5 clk = ~clk;

   // number of rising edges seen so far
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mregs [NR];

   task automatic check(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic addr_ok(input logic [15:0] a);
`ifdef DLA_AXI_LITE_S_ADDR_ERR_EN
      return (a >= BASE) && (a < BASE + 16'(NR*DW/8));
`else
      return 1'b1;
`endif
   endfunction

   function automatic int unsigned model_idx(input logic [15:0] a);
      logic [15:0] off;
      off = a - BASE;
      return (int'(off) / (DW/8)) % NR;
   endfunction

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      f = '0;
      for (int k = 0; k < NR; k++) f[k*DW +: DW] = mregs[k];
      return f;
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
      int unsigned ix;
      if (addr_ok(a)) begin
         ix = model_idx(a);
         for (int b = 0; b < DW/8; b++)
            if (s[b]) mregs[ix][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [15:0] a);
      return addr_ok(a) ? mregs[model_idx(a)] : '0;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NR; k++) mregs[k] = '0;
   endtask

   // ---------------- channel drivers ----------------
   task automatic drive_aw(input logic [15:0] a, input int dly, output int unsigned hs);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      repeat (dly) @(negedge clk);
      awaddr  = a;
      awvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (awready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) check("aw_timeout", 0, 1);
      hs = cyc + 1;
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   task automatic drive_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input int dly, output int unsigned hs);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      repeat (dly) @(negedge clk);
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (wready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) check("w_timeout", 0, 1);
      hs = cyc + 1;
      @(posedge clk); #1;
      wvalid = 1'b0;
   endtask

   // full write transaction with B held off for 'hold' cycles
   task automatic do_write(input logic [15:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                           input int aw_dly, input int w_dly, input int hold);
      int unsigned ah, wh, later, b_at;
      logic found;
      logic [1:0] exp_resp;
      fork
         drive_aw(a, aw_dly, ah);
         drive_w(d, s, w_dly, wh);
      join
      later = (ah > wh) ? ah : wh;
      found = 1'b0;
      b_at  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bvalid) begin found = 1'b1; b_at = cyc; break; end
      end
      check("b_timeout", found, 1);
      if (found) begin
         check("b_latency", b_at - later, 1);
         model_write(a, d, s);
         exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
         for (int i = 0; i < hold; i++) begin
            check("b_hold_valid", bvalid, 1);
            check("b_hold_resp", bresp, exp_resp);
            check("b_hold_awready", awready, 0);
            check("b_hold_wready", wready, 0);
            @(negedge clk);
         end
         check("bresp", bresp, exp_resp);
         check("regs_after_write", regs, model_flat());
         bready = 1'b1;
         @(posedge clk); #1;
         bready = 1'b0;
         @(negedge clk);
         check("b_clear", bvalid, 0);
      end
   endtask

   task automatic do_read(input logic [15:0] a, input int hold);
      logic ok;
      logic [DW-1:0] exp_d;
      logic [1:0] exp_r;
      ok = 1'b0;
      @(negedge clk);
      araddr  = a;
      arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (arready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) check("ar_timeout", 0, 1);
      exp_d = model_read(a);
      exp_r = addr_ok(a) ? 2'b00 : 2'b10;
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("rvalid", rvalid, 1);
      for (int i = 0; i < hold; i++) begin
         check("r_hold_data", rdata, exp_d);
         check("r_hold_arready", arready, 0);
         @(negedge clk);
      end
      check("rdata", rdata, exp_d);
      check("rresp", rresp, exp_r);
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      check("r_clear", rvalid, 0);
   endtask

   // ---------------- main sequence ----------------
   logic [DW-1:0] old0;
   logic [15:0]   ra;

   initial begin
      rstn = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
      bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
      model_clear();

      // reset and idle
      repeat (3) @(negedge clk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_arready", arready, 0);
      rstn = 1'b1;
      #1;
      check("idle_awready", awready, 1);
      check("idle_wready", wready, 1);
      check("idle_arready", arready, 1);
      check("idle_bvalid", bvalid, 0);
      check("idle_rvalid", rvalid, 0);
      check("idle_regs", regs, '0);

      // full write then read back
      do_write(16'h5004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      check("reg1_full", regs[63:32], 32'hDEADBEEF);
      do_read(16'h5004, 0);

      // W first, AW three cycles later, partial strobes
      do_write(16'h5004, 32'h12345678, 4'b0011, 3, 0, 0);
      check("reg1_partial", regs[63:32], 32'hDEAD5678);

      // B held off for five cycles, then a second write
      do_write(16'h5008, 32'hCAFEF00D, 4'hF, 0, 1, 5);
      do_write(16'h500C, 32'h01020304, 4'hF, 2, 0, 0);

      // zero strobes leave the register unchanged
      do_write(16'h5008, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
      check("zero_strb", regs[95:64], 32'hCAFEF00D);

`ifdef DLA_AXI_LITE_S_ADDR_ERR_EN
      do_write(16'h6000, 32'h55AA55AA, 4'hF, 0, 0, 0);
      do_read(16'h6000, 1);
`else
      do_write(16'h5020, 32'h0BADCAFE, 4'hF, 0, 0, 0);
      check("alias_reg0", regs[31:0], 32'h0BADCAFE);
      do_read(16'h5020, 1);
`endif

      // AR to reg0 on the same edge as a write commit to reg0
      do_write(BASE, 32'hA5A50001, 4'hF, 0, 0, 0);
      @(negedge clk);
      awaddr = BASE; wdata = 32'h0BADF00D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      check("cc_awready", awready, 1);
      check("cc_wready", wready, 1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      araddr = BASE; arvalid = 1'b1;
      check("cc_arready", arready, 1);
      old0 = mregs[0];
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("cc_bvalid", bvalid, 1);
      check("cc_rvalid", rvalid, 1);
      check("cc_rdata_old", rdata, old0);
      model_write(BASE, 32'h0BADF00D, 4'hF);
      check("cc_regs", regs, model_flat());
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         int unsigned sel;
         logic [15:0] wa;
         sel = $urandom_range(0, 9);
         if (sel < 7)       wa = BASE + 16'($urandom_range(0, NR*DW/8 - 1));
         else if (sel < 9)  wa = BASE + 16'(NR*DW/8) + 16'($urandom_range(0, 255));
         else               wa = 16'($urandom_range(0, 16'h4FFF));
         do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         if (sel < 8) ra = BASE + 16'($urandom_range(0, NR*DW/8 - 1));
         else         ra = 16'($urandom);
         do_read(ra, $urandom_range(0, 3));
      end

      // reset while a write response is pending
      @(negedge clk);
      awaddr = BASE + 16'd4; wdata = 32'h77777777; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_bvalid", bvalid, 1);
      rstn = 1'b0;
      @(posedge clk); #1;
      check("rst_bvalid_clear", bvalid, 0);
      check("rst_regs_clear", regs, '0);
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("post_rst_awready", awready, 1);
      do_write(16'h501C, 32'h89ABCDEF, 4'b1100, 1, 0, 0);
      do_read(16'h501C, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // overall watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
